// File: rtl/lfsr_pkg.sv
// Tap tables, monitor state type and period helper shared by the LFSR generator files.
package lfsr_pkg;

    typedef enum logic {MON_RUN, MON_DONE} mon_state_t;

    // Fibonacci feedback mask: bit i set means state[i] joins the XOR.
    function automatic logic [31:0] fib_taps(input int width);
        case (width)
            2:       fib_taps = 32'h0000_0003;
            3:       fib_taps = 32'h0000_0005;
            4:       fib_taps = 32'h0000_0009;
            5:       fib_taps = 32'h0000_0012;
            6:       fib_taps = 32'h0000_0021;
            7:       fib_taps = 32'h0000_0041;
            8:       fib_taps = 32'h0000_008E;
            9:       fib_taps = 32'h0000_0108;
            10:      fib_taps = 32'h0000_0204;
            11:      fib_taps = 32'h0000_0402;
            12:      fib_taps = 32'h0000_0CA0;
            13:      fib_taps = 32'h0000_1B00;
            14:      fib_taps = 32'h0000_3500;
            15:      fib_taps = 32'h0000_4001;
            16:      fib_taps = 32'h0000_8805;
            17:      fib_taps = 32'h0001_0004;
            18:      fib_taps = 32'h0002_0040;
            19:      fib_taps = 32'h0007_1000;
            20:      fib_taps = 32'h0008_0004;
            21:      fib_taps = 32'h0010_0002;
            22:      fib_taps = 32'h0020_0001;
            23:      fib_taps = 32'h0040_0010;
            24:      fib_taps = 32'h0080_0043;
            25:      fib_taps = 32'h0100_0004;
            26:      fib_taps = 32'h0388_0000;
            27:      fib_taps = 32'h0720_0000;
            28:      fib_taps = 32'h0800_0004;
            29:      fib_taps = 32'h1000_0002;
            30:      fib_taps = 32'h3280_0000;
            31:      fib_taps = 32'h4000_0004;
            32:      fib_taps = 32'hE000_0200;
            default: fib_taps = 32'h0000_0000;
        endcase
    endfunction

    // Galois mask: the same polynomials as fib_taps with the x^WIDTH term dropped.
    function automatic logic [31:0] galois_mask(input int width);
        case (width)
            2:       galois_mask = 32'h0000_0003;
            3:       galois_mask = 32'h0000_0005;
            4:       galois_mask = 32'h0000_0009;
            5:       galois_mask = 32'h0000_0009;
            6:       galois_mask = 32'h0000_0021;
            7:       galois_mask = 32'h0000_0041;
            8:       galois_mask = 32'h0000_0071;
            9:       galois_mask = 32'h0000_0021;
            10:      galois_mask = 32'h0000_0081;
            11:      galois_mask = 32'h0000_0201;
            12:      galois_mask = 32'h0000_0053;
            13:      galois_mask = 32'h0000_001B;
            14:      galois_mask = 32'h0000_002B;
            15:      galois_mask = 32'h0000_4001;
            16:      galois_mask = 32'h0000_A011;
            17:      galois_mask = 32'h0000_4001;
            18:      galois_mask = 32'h0000_0801;
            19:      galois_mask = 32'h0000_0047;
            20:      galois_mask = 32'h0002_0001;
            21:      galois_mask = 32'h0008_0001;
            22:      galois_mask = 32'h0020_0001;
            23:      galois_mask = 32'h0004_0001;
            24:      galois_mask = 32'h00C2_0001;
            25:      galois_mask = 32'h0040_0001;
            26:      galois_mask = 32'h0000_0047;
            27:      galois_mask = 32'h0000_0027;
            28:      galois_mask = 32'h0200_0001;
            29:      galois_mask = 32'h0800_0001;
            30:      galois_mask = 32'h0000_0053;
            31:      galois_mask = 32'h1000_0001;
            32:      galois_mask = 32'h0040_0007;
            default: galois_mask = 32'h0000_0000;
        endcase
    endfunction

    function automatic logic [32:0] max_period(input int width);
        max_period = (33'd1 << width) - 33'd1;
    endfunction

endpackage

// File: rtl/lfsr_gen_if.sv
// Control and status bundle between an lfsr_gen instance and its user.
interface lfsr_gen_if #(parameter int WIDTH = 4);
    logic             en;
    logic             load;
    logic [WIDTH-1:0] seed;
    logic [WIDTH-1:0] state;
    logic             out_bit;
    logic             zero_seed;
    logic             period_valid;
    logic [WIDTH:0]   period;
    logic             period_max;
    logic             timeout;

    modport master (
        output en, load, seed,
        input  state, out_bit, zero_seed, period_valid, period, period_max, timeout
    );

    modport slave (
        input  en, load, seed,
        output state, out_bit, zero_seed, period_valid, period, period_max, timeout
    );
endinterface

// File: rtl/lfsr_period_mon.sv
// Counts steps from the start value until the LFSR returns to it or 2^WIDTH steps pass.
//   MON_RUN  | counting steps, comparing next state against the start value
//   MON_DONE | period or timeout captured; outputs frozen until load or reset
module lfsr_period_mon
    import lfsr_pkg::*;
#(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = {{(WIDTH-1){1'b0}}, 1'b1}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_step,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic [WIDTH-1:0] i_next_state,
    output logic             o_period_valid,
    output logic [WIDTH:0]   o_period,
    output logic             o_period_max,
    output logic             o_timeout
);
    localparam logic [32:0]    MAXP_FULL = max_period(WIDTH);
    localparam logic [32:0]    WRAP_FULL = MAXP_FULL + 33'd1;
    localparam logic [WIDTH:0] MAXP      = MAXP_FULL[WIDTH:0];
    localparam logic [WIDTH:0] WRAP      = WRAP_FULL[WIDTH:0];
    localparam logic [WIDTH:0] CNT_ONE   = {{WIDTH{1'b0}}, 1'b1};

    mon_state_t       r_mon;
    mon_state_t       w_mon_nxt;
    logic [WIDTH-1:0] r_ref;
    logic [WIDTH:0]   r_cnt;
    logic [WIDTH:0]   w_cnt_inc;
    logic             w_run_step;
    logic             w_hit;
    logic             w_wrap;

    always_ff @(posedge clk) begin
        if (reset) r_mon <= MON_RUN;
        else       r_mon <= w_mon_nxt;
    end

    always_comb begin
        w_mon_nxt = r_mon;
        if (i_load)                           w_mon_nxt = MON_RUN;
        else if (w_run_step && (w_hit || w_wrap)) w_mon_nxt = MON_DONE;
    end

    always_comb begin
        w_cnt_inc  = r_cnt + CNT_ONE;
        w_run_step = (r_mon == MON_RUN) && i_step && !i_load;
        w_hit      = (i_next_state == r_ref);
        w_wrap     = (w_cnt_inc == WRAP);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ref          <= RESET_VAL;
            r_cnt          <= '0;
            o_period       <= '0;
            o_period_valid <= 1'b0;
            o_period_max   <= 1'b0;
            o_timeout      <= 1'b0;
        end else if (i_load) begin
            r_ref          <= i_load_val;
            r_cnt          <= '0;
            o_period       <= '0;
            o_period_valid <= 1'b0;
            o_period_max   <= 1'b0;
            o_timeout      <= 1'b0;
        end else if (w_run_step) begin
            r_cnt <= w_cnt_inc;
            // A return to the start value wins over the wrap on the same step.
            if (w_hit) begin
                o_period       <= w_cnt_inc;
                o_period_valid <= 1'b1;
                o_period_max   <= (w_cnt_inc == MAXP);
            end else if (w_wrap) begin
                o_timeout <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/lfsr_gen.sv
// Maximal-length LFSR with seed guard and period monitor.
// Define LFSR_GALOIS_EN for the Galois form; the default build is Fibonacci.
module lfsr_gen
    import lfsr_pkg::*;
#(
    parameter int          WIDTH      = 4,
    parameter logic [31:0] RESET_SEED = 32'd1,
    parameter logic [31:0] TAP_MASK   = 32'd0  // nonzero replaces the table polynomial
) (
    input  logic       clk,
    input  logic       reset,
    lfsr_gen_if.slave  bus
);
    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $error("lfsr_gen: WIDTH must be in 2..32");
    end

    localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] SEED_LO = RESET_SEED[WIDTH-1:0];
    localparam logic [WIDTH-1:0] SEED0   = (SEED_LO == '0) ? ONE : SEED_LO;
`ifdef LFSR_GALOIS_EN
    localparam logic [31:0] MASK_FULL = (TAP_MASK != 32'd0) ? TAP_MASK : galois_mask(WIDTH);
`else
    localparam logic [31:0] MASK_FULL = (TAP_MASK != 32'd0) ? TAP_MASK : fib_taps(WIDTH);
`endif
    localparam logic [WIDTH-1:0] MASK = MASK_FULL[WIDTH-1:0];

    logic [WIDTH-1:0] r_state;
    logic             r_zero_seed;
    logic [WIDTH-1:0] w_next;
    logic [WIDTH-1:0] w_load_val;
    logic             w_step;

    always_comb begin
`ifdef LFSR_GALOIS_EN
        w_next = {r_state[WIDTH-2:0], 1'b0} ^ (r_state[WIDTH-1] ? MASK : '0);
`else
        w_next = {r_state[WIDTH-2:0], ^(r_state & MASK)};
`endif
        // All-zero is a fixed point of both forms, so a zero seed is never let in.
        w_load_val = (bus.seed == '0) ? ONE : bus.seed;
        w_step     = bus.en && !bus.load;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= SEED0;
            r_zero_seed <= 1'b0;
        end else begin
            r_zero_seed <= bus.load && (bus.seed == '0);
            if (bus.load)    r_state <= w_load_val;
            else if (w_step) r_state <= w_next;
        end
    end

    lfsr_period_mon #(
        .WIDTH     (WIDTH),
        .RESET_VAL (SEED0)
    ) u_mon (
        .clk            (clk),
        .reset          (reset),
        .i_step         (w_step),
        .i_load         (bus.load),
        .i_load_val     (w_load_val),
        .i_next_state   (w_next),
        .o_period_valid (bus.period_valid),
        .o_period       (bus.period),
        .o_period_max   (bus.period_max),
        .o_timeout      (bus.timeout)
    );

    assign bus.state     = r_state;
    assign bus.out_bit   = r_state[WIDTH-1];
    assign bus.zero_seed = r_zero_seed;
endmodule

// File: tb/tb_lfsr_gen.sv
// Scoreboard bench for lfsr_gen (Fibonacci build): directed WIDTH=4 runs plus 8/16-bit and override-mask runs.
module tb_lfsr_gen;
    logic clk = 1'b0;
    logic reset;
    logic aux_reset;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   aux_start = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    lfsr_gen_if #(.WIDTH(4))  m_if ();
    lfsr_gen_if #(.WIDTH(8))  a8_if ();
    lfsr_gen_if #(.WIDTH(16)) a16_if ();
    lfsr_gen_if #(.WIDTH(4))  ar_if ();
    lfsr_gen_if #(.WIDTH(4))  at_if ();

    lfsr_gen #(.WIDTH(4),  .RESET_SEED(32'd1)) u_dut (.clk(clk), .reset(reset),     .bus(m_if));
    lfsr_gen #(.WIDTH(8),  .RESET_SEED(32'd1)) u_w8  (.clk(clk), .reset(aux_reset), .bus(a8_if));
    lfsr_gen #(.WIDTH(16), .RESET_SEED(32'd1)) u_w16 (.clk(clk), .reset(aux_reset), .bus(a16_if));
    // Mask 8 is a pure rotate (period 4); mask 1 latches into 1111 and never returns (timeout).
    lfsr_gen #(.WIDTH(4), .RESET_SEED(32'd1), .TAP_MASK(32'h8)) u_rot (.clk(clk), .reset(aux_reset), .bus(ar_if));
    lfsr_gen #(.WIDTH(4), .RESET_SEED(32'd0), .TAP_MASK(32'h1)) u_stk (.clk(clk), .reset(aux_reset), .bus(at_if));

    // Hand-computed Fibonacci WIDTH=4, taps 4'h9, starting from 0001.
    logic [3:0] seq4 [15] = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hD, 4'hA, 4'h5,
                              4'hB, 4'h6, 4'hC, 4'h9, 4'h2, 4'h4, 4'h8};
    int    idx = 0;
    int    run_k = 0;
    string tname = "";

    typedef enum int {F_STATE, F_BIT, F_PV, F_PERIOD, F_PMAX, F_TO, F_ZS} fld_t;
    typedef struct { int cyc; fld_t fld; logic [31:0] exp; string name; } cchk_t;
    typedef struct { logic [31:0] period; logic pmax; logic to; string name; } pev_t;
    typedef struct { logic [31:0] steps; logic [31:0] period; logic pmax; logic to; } aux_t;

    cchk_t cq[$];
    pev_t  pq[$];
    aux_t  q8[$];
    aux_t  q16[$];
    aux_t  qrot[$];
    aux_t  qstk[$];

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endfunction

    function automatic logic [31:0] fld_val(fld_t f);
        case (f)
            F_STATE:  fld_val = 32'(m_if.state);
            F_BIT:    fld_val = 32'(m_if.out_bit);
            F_PV:     fld_val = 32'(m_if.period_valid);
            F_PERIOD: fld_val = 32'(m_if.period);
            F_PMAX:   fld_val = 32'(m_if.period_max);
            F_TO:     fld_val = 32'(m_if.timeout);
            default:  fld_val = 32'(m_if.zero_seed);
        endcase
    endfunction

    function automatic void expect_(fld_t f, logic [31:0] v, string n);
        cchk_t c;
        c.cyc  = cyc + 1;
        c.fld  = f;
        c.exp  = v;
        c.name = {tname, " ", n};
        cq.push_back(c);
    endfunction

    function automatic void push_exp(input logic zs);
        logic pv;
        pv = (run_k >= 15);
        expect_(F_STATE,  32'(seq4[idx]),    "state");
        expect_(F_BIT,    32'(seq4[idx][3]), "out_bit");
        expect_(F_PV,     32'(pv),           "period_valid");
        expect_(F_PERIOD, pv ? 32'd15 : 32'd0, "period");
        expect_(F_PMAX,   32'(pv),           "period_max");
        expect_(F_TO,     32'd0,             "timeout");
        expect_(F_ZS,     32'(zs),           "zero_seed");
    endfunction

    function automatic void push_run(string n);
        pev_t p;
        p.period = 32'd15;
        p.pmax   = 1'b1;
        p.to     = 1'b0;
        p.name   = n;
        pq.push_back(p);
    endfunction

    task automatic drive(input logic en_v, input logic ld, input logic [3:0] sd);
        m_if.en   = en_v;
        m_if.load = ld;
        m_if.seed = sd;
        @(posedge clk);
        #1;
    endtask

    task automatic step1(input logic en_v);
        if (en_v) begin
            idx = (idx + 1) % 15;
            run_k++;
        end
        push_exp(1'b0);
        drive(en_v, 1'b0, 4'h0);
    endtask

    // Per-cycle monitor for the main instance.
    always @(negedge clk) begin
        cchk_t c;
        while (cq.size() > 0 && cq[0].cyc <= cyc) begin
            c = cq.pop_front();
            chk(c.name, fld_val(c.fld), c.exp);
        end
    end

    // Period-event monitor: fires when period_valid or timeout rises.
    logic m_done_q = 1'b0;
    always @(negedge clk) begin
        logic m_done;
        pev_t p;
        m_done = (m_if.period_valid === 1'b1) || (m_if.timeout === 1'b1);
        if (m_done && !m_done_q) begin
            if (pq.size() == 0) begin
                chk("period event without pending run", 32'(m_done), 32'd0);
            end else begin
                p = pq.pop_front();
                chk({p.name, " period"},     32'(m_if.period),     p.period);
                chk({p.name, " period_max"}, 32'(m_if.period_max), 32'(p.pmax));
                chk({p.name, " timeout"},    32'(m_if.timeout),    32'(p.to));
            end
        end
        m_done_q = m_done;
    end

    function automatic void aux_cmp(string n, aux_t e, int steps, logic [31:0] per, logic pm, logic to);
        chk({n, " steps to event"}, 32'(steps), e.steps);
        chk({n, " period"},         per,        e.period);
        chk({n, " period_max"},     32'(pm),    32'(e.pmax));
        chk({n, " timeout"},        32'(to),    32'(e.to));
    endfunction

    always @(negedge clk) begin
        if (q8.size() > 0 && (a8_if.period_valid === 1'b1 || a8_if.timeout === 1'b1))
            aux_cmp("w8", q8.pop_front(), cyc - aux_start, 32'(a8_if.period), a8_if.period_max, a8_if.timeout);
        if (q16.size() > 0 && (a16_if.period_valid === 1'b1 || a16_if.timeout === 1'b1))
            aux_cmp("w16", q16.pop_front(), cyc - aux_start, 32'(a16_if.period), a16_if.period_max, a16_if.timeout);
        if (qrot.size() > 0 && (ar_if.period_valid === 1'b1 || ar_if.timeout === 1'b1))
            aux_cmp("mask8", qrot.pop_front(), cyc - aux_start, 32'(ar_if.period), ar_if.period_max, ar_if.timeout);
        if (qstk.size() > 0 && (at_if.period_valid === 1'b1 || at_if.timeout === 1'b1))
            aux_cmp("mask1", qstk.pop_front(), cyc - aux_start, 32'(at_if.period), at_if.period_max, at_if.timeout);
    end

    initial begin
        reset     = 1'b1;
        aux_reset = 1'b1;
        m_if.en = 1'b0;  m_if.load = 1'b0;  m_if.seed = '0;
        a8_if.en = 1'b0; a8_if.load = 1'b0; a8_if.seed = '0;
        a16_if.en = 1'b0; a16_if.load = 1'b0; a16_if.seed = '0;
        ar_if.en = 1'b0; ar_if.load = 1'b0; ar_if.seed = '0;
        at_if.en = 1'b0; at_if.load = 1'b0; at_if.seed = '0;

        tname = "reset"; idx = 0; run_k = 0;
        push_exp(1'b0);
        drive(1'b0, 1'b0, 4'h0);
        push_exp(1'b0);
        drive(1'b0, 1'b0, 4'h0);
        reset     = 1'b0;
        aux_reset = 1'b0;

        aux_start = cyc;
        q8.push_back('{32'd255, 32'd255, 1'b1, 1'b0});
        q16.push_back('{32'd65535, 32'd65535, 1'b1, 1'b0});
        qrot.push_back('{32'd4, 32'd4, 1'b0, 1'b0});
        qstk.push_back('{32'd16, 32'd0, 1'b0, 1'b1});
        a8_if.en = 1'b1; a16_if.en = 1'b1; ar_if.en = 1'b1; at_if.en = 1'b1;

        tname = "free run";
        push_run("free run");
        for (int i = 0; i < 18; i++) step1(1'b1);

        tname = "seed A"; idx = 6; run_k = 0;
        push_run("seed A");
        push_exp(1'b0);
        drive(1'b0, 1'b1, 4'hA);
        for (int i = 0; i < 15; i++) step1(1'b1);

        tname = "seed 0"; idx = 0; run_k = 0;
        push_run("seed 0");
        push_exp(1'b1);
        drive(1'b0, 1'b1, 4'h0);
        step1(1'b0);
        for (int i = 0; i < 15; i++) step1(1'b1);

        tname = "load+en"; idx = 7; run_k = 0;
        push_run("load+en");
        push_exp(1'b0);
        drive(1'b1, 1'b1, 4'h5);
        for (int g = 0; run_k < 15; g++)
            step1((g < 40) ? 1'($urandom_range(0, 1)) : 1'b1);

        tname = "done hold";
        for (int i = 0; i < 7; i++) step1(1'b1);

        tname = "reset after done"; reset = 1'b1; idx = 0; run_k = 0;
        push_exp(1'b0);
        drive(1'b1, 1'b1, 4'hA);
        reset = 1'b0;

        tname = "partial run";
        for (int i = 0; i < 7; i++) step1(1'b1);

        tname = "reset mid-run"; reset = 1'b1; idx = 0; run_k = 0;
        push_exp(1'b0);
        drive(1'b1, 1'b1, 4'h3);
        reset = 1'b0;

        tname = "fresh run";
        push_run("fresh run");
        for (int i = 0; i < 15; i++) step1(1'b1);

        for (int g = 0; g < 70000 && (q8.size() + q16.size() + qrot.size() + qstk.size()) > 0; g++)
            @(posedge clk);
        chk("aux runs outstanding", 32'(q8.size() + q16.size() + qrot.size() + qstk.size()), 32'd0);
        @(negedge clk);
        #1;
        chk("pending cycle checks", 32'(cq.size()), 32'd0);
        chk("pending period events", 32'(pq.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
